// File: rtl/dlatch_bank_writer.sv
// Write-side driver for a bank of level-sensitive D latches.
// Serialises a parallel word onto one shared data line, LSB first.
// Each bit is written as setup, then a one-hot gate pulse, then hold.
// Also issues a bank-wide clear on the latches' active-low reset.
module dlatch_bank_writer #(
  parameter int unsigned N     = 8,
  parameter int unsigned SETUP = 1,
  parameter int unsigned PULSE = 1,
  parameter int unsigned HOLD  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         clear,
  input  logic [N-1:0] din,
  output logic         busy,
  output logic         done,
  output logic         lat_d,
  output logic [N-1:0] lat_gate,
  output logic         lat_rst_n
);

  localparam int unsigned MaxSp = (SETUP > PULSE) ? SETUP : PULSE;
  localparam int unsigned MaxT  = (MaxSp > HOLD) ? MaxSp : HOLD;
  localparam int unsigned CntW  = $clog2(MaxT + 1);
  localparam int unsigned IdxW  = $clog2(N + 1);

  typedef enum logic [2:0] {StIdle, StClr, StSetup, StGate, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  // Word being written; shifted right per bit so bit 0 is always the current one.
  logic [N-1:0]    shadow_q, shadow_d;
  logic            fin;

  logic            busy_d, done_d, lat_d_d, lat_rst_n_d;
  logic [N-1:0]    lat_gate_d;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  // Next-state logic: each phase dwells for its cycle count, then advances.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    fin      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          state_d = StClr;
          cnt_d   = '0;
        end else if (start) begin
          state_d  = StSetup;
          shadow_d = din;
          idx_d    = '0;
          cnt_d    = '0;
        end
      end
      StClr: begin
        if (cnt_q == CntW'(PULSE - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          fin     = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(SETUP - 1)) begin
          state_d = StGate;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGate: begin
        if (cnt_q == CntW'(PULSE - 1)) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == CntW'(HOLD - 1)) begin
          cnt_d = '0;
          if (idx_q == IdxW'(N - 1)) begin
            state_d = StIdle;
            fin     = 1'b1;
          end else begin
            state_d  = StSetup;
            idx_d    = idx_q + IdxW'(1);
            shadow_d = shadow_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  // lat_d only changes on entry to setup, when the gate is guaranteed closed.
  always_comb begin
    busy_d      = (state_d != StIdle);
    done_d      = fin;
    lat_rst_n_d = (state_d != StClr);
    lat_gate_d  = (state_d == StGate) ? (N'(1) << idx_d) : '0;
    lat_d_d     = (state_d == StSetup) ? shadow_d[0] : lat_d;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      lat_d     <= 1'b0;
      lat_gate  <= '0;
      lat_rst_n <= 1'b1;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      lat_d     <= lat_d_d;
      lat_gate  <= lat_gate_d;
      lat_rst_n <= lat_rst_n_d;
    end
  end

endmodule
